// File: rtl/uart_rcv.sv
// uart_rcv: 8N1 serial receiver. Synchronises RX, detects the start edge,
// samples each bit at its mid-point and presents the byte with sticky
// rdy / frame_err flags that the consumer acknowledges with clr_rdy.
module uart_rcv #(
    parameter int BAUD_CNT = 2604   // clocks per bit period, must be >= 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frame_err
);

    typedef enum logic {
        IDLE      = 1'b0,
        RECEIVING = 1'b1
    } state_t;

    // First sample lands mid start bit; later samples are one full period apart.
    localparam logic [11:0] HALF_RELOAD = 12'(BAUD_CNT / 2 - 1);
    localparam logic [11:0] FULL_RELOAD = 12'(BAUD_CNT - 1);

    state_t      state_q, state_d;
    logic        rx_meta_q, rx_s_q;
    logic [11:0] baud_cnt_q, baud_cnt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [8:0]  shift_reg_q, shift_reg_d;
    logic        shift, start_det, done;
    logic        rdy_q, frame_err_q;
    logic [7:0]  rx_data_q;

    // Two-flop synchroniser for the asynchronous line; presets to idle-high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples the pre-edge value of its source, whatever the statement order.
            rx_meta_q <= RX;
            rx_s_q    <= rx_meta_q;
        end
    end

    assign shift = (state_q == RECEIVING) && (baud_cnt_q == 12'd0);

    // Next-state logic: start detect, bit timing, glitch reject, completion.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        baud_cnt_d  = baud_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_reg_d = shift_reg_q;
        start_det   = 1'b0;
        done        = 1'b0;
        case (state_q)
            IDLE: begin
                baud_cnt_d = HALF_RELOAD;
                bit_cnt_d  = 4'd0;
                if (!rx_s_q) begin
                    start_det = 1'b1;
                    state_d   = RECEIVING;
                end
            end
            RECEIVING: begin
                baud_cnt_d = baud_cnt_q - 12'd1;
                if (shift) begin
                    baud_cnt_d  = FULL_RELOAD;
                    bit_cnt_d   = bit_cnt_q + 4'd1;
                    shift_reg_d = {rx_s_q, shift_reg_q[8:1]};
                    if (bit_cnt_q == 4'd0 && rx_s_q) begin
                        // Line was high again at the start-bit mid-point: glitch.
                        state_d = IDLE;
                    end else if (bit_cnt_q == 4'd9) begin
                        // Stop-bit sample: back to IDLE so a following start is seen.
                        state_d = IDLE;
                        done    = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Bit timing counters and the receive shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt_q  <= HALF_RELOAD;
            bit_cnt_q   <= 4'd0;
            shift_reg_q <= 9'h1FF;
        end else begin
            baud_cnt_q  <= baud_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_reg_q <= shift_reg_d;
        end
    end

    // Output byte and sticky flags: completion wins over clr_rdy / start detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_q   <= 8'h00;
            rdy_q       <= 1'b0;
            frame_err_q <= 1'b0;
        end else if (done) begin
            rx_data_q   <= shift_reg_d[7:0];
            rdy_q       <= 1'b1;
            frame_err_q <= ~rx_s_q;
        end else if (clr_rdy || start_det) begin
            rdy_q       <= 1'b0;
            frame_err_q <= 1'b0;
        end
    end

    assign rx_data   = rx_data_q;
    assign rdy       = rdy_q;
    assign frame_err = frame_err_q;

endmodule

// File: doc/uart_rcv.md
# uart_rcv

UART serial receiver, the downstream partner of the team's UART transmitter. It deserialises an 8N1 stream (one start bit, 8 data bits LSB first, one stop bit) from the `RX` line, sampling mid-bit at a fixed baud period. It presents each received byte on `rx_data` with a sticky `rdy` flag that the consuming logic acknowledges with `clr_rdy`. It is used in loopback against the transmitter and as the command-input front end.

## Interface
- `BAUD_CNT`, default 2604: clocks per bit period (50 MHz / 19200 baud). Must be ≥ 4.
- `clk`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  reset, asynchronous, active-low. Clock is `clk`.
- `RX`  in  1  asynchronous serial input; idles high.
- `clr_rdy`  in  1  synchronous acknowledge; clears `rdy` and `frame_err`.
- `rx_data`  out  8  last received byte; held until the next byte completes.
- `rdy`  out  1  sticky byte-valid flag.
- `frame_err`  out  1  sticky; the stop bit of the last byte sampled 0. Valid when `rdy`=1.

## Operation
- **RX synchronisation**
  - Two flops synchronise `RX`; both preset to 1 on reset.
  - All logic uses the second flop (`rx_s`) only.
- **State machine**: two states, IDLE and RECEIVING.
- **IDLE**
  - When `rx_s`=0, go to RECEIVING.
  - Load `baud_cnt` with `BAUD_CNT/2 - 1` (integer divide) and clear `bit_cnt`.
  - Clear `rdy` and `frame_err` (the start of a new byte invalidates the old flag).
- **RECEIVING**
  - `baud_cnt` (12 bits) decrements every cycle.
  - `shift` asserts combinationally when `baud_cnt`=0.
  - On `shift`:
    - reload `baud_cnt` with `BAUD_CNT - 1`;
    - increment `bit_cnt` (4 bits);
    - shift the 9-bit register right with `rx_s` entering at bit 8.
- **Start-bit check**
  - At the first `shift` (`bit_cnt`=0), if `rx_s`=1 the start bit is a glitch.
  - Return to IDLE; do not set `rdy`; leave `rx_data` unchanged.
- **Completion**
  - On the `shift` that makes `bit_cnt` reach 10, return to IDLE and set `rdy`.
  - Set `frame_err` to the inverse of the sampled stop bit.
  - `rx_data` = shift register bits [7:0]; bit 8 holds the stop bit.
- **`rdy` / `frame_err` flops**
  - Set/reset flops with priority: reset, then set (completion), then clear (`clr_rdy` or start detect).
  - `clr_rdy` asserted in the same cycle as completion is ignored: the new byte wins.
- **`rx_data`**: register output, updated only at completion.
- **Back-to-back frames**: IDLE is entered in the stop-bit mid-point cycle, so a start edge arriving immediately after the stop bit is detected normally.
- **Reset mid-frame**: immediate return to IDLE; the partial byte is discarded.
- **Reset values**: `rdy`=0, `frame_err`=0, `rx_data`=8'h00, state IDLE, both synchroniser flops 1, shift register 9'h1FF.

## Timing
- `RX` to `rx_s` latency: 2 clk.
- Start detect (cycle T, `rx_s` first low, IDLE):
  - first sample (start-bit mid) at T+`BAUD_CNT/2`;
  - sample k (k=1..9) at T+`BAUD_CNT/2`+k·`BAUD_CNT`.
- `rdy`, `frame_err` and `rx_data` are visible one clock after the 10th sample.
  - At the default, this is 24739 clk after T, or 24741 clk after the `RX` falling edge.
- Glitch rejection: a low pulse shorter than `BAUD_CNT/2` clk produces no `rdy`.
  - The block returns to IDLE one clock after the start-bit sample.
- `clr_rdy` takes effect on the next clock edge.
- There is no back-pressure. If `rdy` is still high when a new start is detected, the flag clears and the previous byte is lost once the next byte completes.

## Test plan
- **Loopback, single byte**: UART transmitter sends 8'h5A into `RX` → exactly one `rdy` rise, `rx_data`=8'h5A, `frame_err`=0; `rdy` rises 24739 clk after `rx_s` falls.
- **Back-to-back bytes**: transmitter sends 8'h00, then 8'hFF, then 8'hA5 with no idle gap, `clr_rdy` pulsed after each → `rdy` pulses three times with `rx_data`=00, FF, A5 in order; `frame_err` stays 0.
- **Glitch rejection**: `RX` low for 1000 clk, then high → `rdy` never asserts, `rx_data` unchanged, state back in IDLE by 1303 clk after detect.
- **Framing error**: drive frame 8'hC3 with the stop bit held low → `rdy`=1, `frame_err`=1, `rx_data`=8'hC3; `clr_rdy` pulse → both flags 0 on the next clock.
- **Set/clear collision**: assert `clr_rdy` in the completion cycle of byte 8'h3C → `rdy`=1 afterward, `rx_data`=8'h3C.
- **Reset mid-frame**: assert `rst_n`=0 during data bit 4 of 8'h96 → `rdy`=0, `rx_data`=00, `frame_err`=0; after release, a following frame 8'h69 is received correctly.
